// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and a
// constant-foldable ceil(log2) helper.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address to register index, plus out-of-range (DECERR) and
// read-only (SLVERR on write) flags derived from RO_MASK.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    output logic [clog2(NUM_REGS)-1:0] o_index,
    output logic                       o_decerr,
    output logic                       o_slverr
);

    localparam int unsigned ADDR_LSB = clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = clog2(NUM_REGS);

    logic [ADDR_WIDTH-1:0] w_word;

    // Byte-offset bits are dropped; anything left above the index field is out of range.
    assign w_word   = i_addr >> ADDR_LSB;
    assign o_index  = w_word[IDX_W-1:0];
    assign o_decerr = |(w_word >> IDX_W);
    assign o_slverr = !o_decerr && RO_MASK[o_index];

endmodule

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, read-only status
// registers fed from reg_in, and SLVERR/DECERR responses.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           axi_lite_aclk,
    input  logic                           axi_lite_aresetn,
    input  logic [ADDR_WIDTH-1:0]          axi_lite_araddr,
    input  logic                           axi_lite_arvalid,
    output logic                           axi_lite_arready,
    output logic [DATA_WIDTH-1:0]          axi_lite_rdata,
    output logic [1:0]                     axi_lite_rresp,
    output logic                           axi_lite_rvalid,
    input  logic                           axi_lite_rready,
    input  logic [ADDR_WIDTH-1:0]          axi_lite_awaddr,
    input  logic                           axi_lite_awvalid,
    output logic                           axi_lite_awready,
    input  logic [DATA_WIDTH-1:0]          axi_lite_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_lite_wstrb,
    input  logic                           axi_lite_wvalid,
    output logic                           axi_lite_wready,
    output logic [1:0]                     axi_lite_bresp,
    output logic                           axi_lite_bvalid,
    input  logic                           axi_lite_bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = clog2(NUM_REGS);

    wr_state_t             r_wstate, w_wstate_nxt;
    rd_state_t             r_rstate, w_rstate_nxt;
    logic                  r_rst_done;
    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic                  w_wr_decerr, w_wr_slverr, w_rd_decerr, w_rd_ro;

    // A beat arriving on the commit edge is used directly rather than via its holding register.
    assign w_wr_addr = r_aw_held ? r_awaddr : axi_lite_awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : axi_lite_wdata;
    assign w_wr_strb = r_w_held  ? r_wstrb  : axi_lite_wstrb;

    assign w_aw_hs = axi_lite_awvalid && axi_lite_awready;
    assign w_w_hs  = axi_lite_wvalid  && axi_lite_wready;
    assign w_ar_hs = axi_lite_arvalid && axi_lite_arready;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_wr_decode (
        .i_addr   (w_wr_addr),
        .o_index  (w_wr_idx),
        .o_decerr (w_wr_decerr),
        .o_slverr (w_wr_slverr)
    );

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_rd_decode (
        .i_addr   (axi_lite_araddr),
        .o_index  (w_rd_idx),
        .o_decerr (w_rd_decerr),
        .o_slverr (w_rd_ro)
    );

    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            r_wstate   <= W_IDLE;
            r_rstate   <= R_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_rstate   <= w_rstate_nxt;
            r_rst_done <= 1'b1;
        end
    end

    always_comb begin
        axi_lite_awready = 1'b0;
        axi_lite_wready  = 1'b0;
        axi_lite_bvalid  = 1'b0;
        w_commit         = 1'b0;
        w_wstate_nxt     = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                axi_lite_awready = r_rst_done && !r_aw_held;
                axi_lite_wready  = r_rst_done && !r_w_held;
                w_commit = (r_aw_held || (axi_lite_awvalid && axi_lite_awready)) &&
                           (r_w_held  || (axi_lite_wvalid  && axi_lite_wready));
                if (w_commit) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                axi_lite_bvalid = 1'b1;
                if (axi_lite_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        axi_lite_arready = 1'b0;
        axi_lite_rvalid  = 1'b0;
        w_rstate_nxt     = r_rstate;
        unique case (r_rstate)
            R_IDLE: begin
                axi_lite_arready = r_rst_done;
                if (axi_lite_arvalid && axi_lite_arready) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                axi_lite_rvalid = 1'b1;
                if (axi_lite_rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= AXI_RESP_OKAY;
            r_wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                if (w_wr_decerr) begin
                    r_bresp <= AXI_RESP_DECERR;
                end else if (w_wr_slverr) begin
                    r_bresp <= AXI_RESP_SLVERR;
                end else begin
                    r_bresp <= AXI_RESP_OKAY;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (w_wr_strb[b]) r_regs[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                    r_wr_pulse[w_wr_idx] <= |w_wr_strb;
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= axi_lite_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= axi_lite_wdata;
                    r_wstrb  <= axi_lite_wstrb;
                end
            end
        end
    end

    // Sampling r_regs here gives a same-edge write's old value to the read.
    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            r_rdata <= '0;
            r_rresp <= AXI_RESP_OKAY;
        end else if (w_ar_hs) begin
            if (w_rd_decerr) begin
                r_rdata <= '0;
                r_rresp <= AXI_RESP_DECERR;
            end else begin
                r_rresp <= AXI_RESP_OKAY;
                r_rdata <= w_rd_ro ? reg_in[w_rd_idx*DATA_WIDTH +: DATA_WIDTH] : r_regs[w_rd_idx];
            end
        end
    end

    assign axi_lite_bresp = r_bresp;
    assign axi_lite_rdata = r_rdata;
    assign axi_lite_rresp = r_rresp;
    assign reg_wr_pulse   = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (32-bit, 16 regs, reg 15 read-only).
module tb_axi_lite_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  araddr, awaddr, wdata, rdata;
    logic         arvalid, arready, rvalid, rready;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;
    logic [1:0]   rresp, bresp;
    logic [511:0] reg_out, reg_in;
    logic [15:0]  reg_wr_pulse;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [1:0]  resp, rr;
    logic [15:0] p1, p2;
    logic [31:0] rd;

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .RO_MASK    (16'h8000)
    ) dut (
        .axi_lite_aclk    (clk),
        .axi_lite_aresetn (rst_n),
        .axi_lite_araddr  (araddr),
        .axi_lite_arvalid (arvalid),
        .axi_lite_arready (arready),
        .axi_lite_rdata   (rdata),
        .axi_lite_rresp   (rresp),
        .axi_lite_rvalid  (rvalid),
        .axi_lite_rready  (rready),
        .axi_lite_awaddr  (awaddr),
        .axi_lite_awvalid (awvalid),
        .axi_lite_awready (awready),
        .axi_lite_wdata   (wdata),
        .axi_lite_wstrb   (wstrb),
        .axi_lite_wvalid  (wvalid),
        .axi_lite_wready  (wready),
        .axi_lite_bresp   (bresp),
        .axi_lite_bvalid  (bvalid),
        .axi_lite_bready  (bready),
        .reg_out          (reg_out),
        .reg_in           (reg_in),
        .reg_wr_pulse     (reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the commit edge plus one more.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] o_resp, output logic [15:0] o_p1, output logic [15:0] o_p2);
        int unsigned n;
        logic aw_fire, w_fire;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            n++;
        end
        check("wr_handshake", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid", bvalid, 1'b1);
        o_resp = bresp;
        o_p1 = reg_wr_pulse;
        @(negedge clk);
        o_p2 = reg_wr_pulse;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] o_data, output logic [1:0] o_resp);
        int unsigned n;
        logic fire;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            fire = arready;
            @(negedge clk);
            if (fire) arvalid = 1'b0;
            n++;
        end
        check("rd_handshake", arvalid, 1'b0);
        arvalid = 1'b0;
        check("rd_rvalid", rvalid, 1'b1);
        o_data = rdata;
        o_resp = rresp;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        reg_in = '0;
        reg_in[15*32 +: 32] = 32'hCAFEF00D;
        reg_in[0 +: 32]     = 32'hDEADBEEF;
        repeat (3) @(negedge clk);

        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", reg_wr_pulse, 16'h0);
        check("rst_reg_out", |reg_out, 1'b0);

        rst_n = 1'b1;
        #1;
        check("rel_awready_low", awready, 1'b0);
        @(negedge clk);
        check("rel_awready", awready, 1'b1);
        check("rel_wready", wready, 1'b1);
        check("rel_arready", arready, 1'b1);

        // 1: simultaneous AW/W
        axi_write(32'h00, 32'h5a5a4b4b, 4'hF, resp, p1, p2);
        check("t1_bresp", resp, 2'b00);
        check("t1_pulse", p1, 16'h0001);
        check("t1_pulse_once", p2, 16'h0000);
        check("t1_reg0", reg_out[0 +: 32], 32'h5a5a4b4b);
        axi_read(32'h00, rd, rr);
        check("t1_rdata", rd, 32'h5a5a4b4b);
        check("t1_rresp", rr, 2'b00);

        // 2: W three cycles ahead of AW
        wdata = 32'h5b5b4a4a; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("t2_wready_held", wready, 1'b0);
        check("t2_no_bvalid0", bvalid, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("t2_no_bvalid", bvalid, 1'b0);
            check("t2_awready", awready, 1'b1);
        end
        awaddr = 32'h04; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("t2_bvalid", bvalid, 1'b1);
        check("t2_bresp", bresp, 2'b00);
        check("t2_pulse", reg_wr_pulse, 16'h0002);
        @(negedge clk);
        check("t2_bvalid_done", bvalid, 1'b0);
        axi_read(32'h04, rd, rr);
        check("t2_rdata", rd, 32'h5b5b4a4a);

        // 3: byte strobes
        axi_write(32'h00, 32'h11223344, 4'b0101, resp, p1, p2);
        check("t3_bresp", resp, 2'b00);
        check("t3_pulse", p1, 16'h0001);
        axi_read(32'h00, rd, rr);
        check("t3_rdata", rd, 32'h5a224b44);
        axi_write(32'h00, 32'hFFFFFFFF, 4'b0000, resp, p1, p2);
        check("t3_strb0_bresp", resp, 2'b00);
        check("t3_strb0_pulse", p1, 16'h0000);
        check("t3_strb0_reg0", reg_out[0 +: 32], 32'h5a224b44);
        axi_read(32'h03, rd, rr);
        check("t3_lowbits_rdata", rd, 32'h5a224b44);

        // 4: read-only and out-of-range
        axi_write(32'h3C, 32'h12345678, 4'hF, resp, p1, p2);
        check("t4_ro_bresp", resp, 2'b10);
        check("t4_ro_pulse", p1, 16'h0000);
        check("t4_ro_reg_out", reg_out[15*32 +: 32], 32'h0);
        axi_read(32'h3C, rd, rr);
        check("t4_ro_rdata", rd, 32'hCAFEF00D);
        check("t4_ro_rresp", rr, 2'b00);
        axi_write(32'h40, 32'h12345678, 4'hF, resp, p1, p2);
        check("t4_dec_bresp", resp, 2'b11);
        check("t4_dec_pulse", p1, 16'h0000);
        check("t4_dec_reg0", reg_out[0 +: 32], 32'h5a224b44);
        axi_read(32'h40, rd, rr);
        check("t4_dec_rdata", rd, 32'h0);
        check("t4_dec_rresp", rr, 2'b11);
        axi_write(32'h8000_0000, 32'h0, 4'hF, resp, p1, p2);
        check("t4_dec_hi_bresp", resp, 2'b11);
        axi_read(32'h00, rd, rr);
        check("t4_rw_ignores_reg_in", rd, 32'h5a224b44);

        // 5: backpressure on B and R
        bready = 1'b0;
        axi_write(32'h10, 32'hA5A5A5A5, 4'hF, resp, p1, p2);
        check("t5_bresp", resp, 2'b00);
        check("t5_pulse", p1, 16'h0010);
        awaddr = 32'h14; wdata = 32'h3C3C3C3C; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_bvalid_hold", bvalid, 1'b1);
            check("t5_bresp_hold", bresp, 2'b00);
            check("t5_awready_low", awready, 1'b0);
            check("t5_wready_low", wready, 1'b0);
            check("t5_reg5_waits", reg_out[5*32 +: 32], 32'h0);
        end
        bready = 1'b1;
        @(negedge clk);
        check("t5_bvalid_drop", bvalid, 1'b0);
        check("t5_awready_back", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("t5_second_bvalid", bvalid, 1'b1);
        check("t5_second_reg5", reg_out[5*32 +: 32], 32'h3C3C3C3C);
        check("t5_second_pulse", reg_wr_pulse, 16'h0020);
        @(negedge clk);

        rready = 1'b0;
        araddr = 32'h00; arvalid = 1'b1;
        @(negedge clk);
        araddr = 32'h3C;
        check("t5_rvalid", rvalid, 1'b1);
        check("t5_rdata", rdata, 32'h5a224b44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_rvalid_hold", rvalid, 1'b1);
            check("t5_rdata_hold", rdata, 32'h5a224b44);
            check("t5_arready_low", arready, 1'b0);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        check("t5_rvalid_drop", rvalid, 1'b0);

        // 6: reset with a write response outstanding
        bready = 1'b0;
        axi_write(32'h08, 32'h12345678, 4'hF, resp, p1, p2);
        check("t6_reg2_written", reg_out[2*32 +: 32], 32'h12345678);
        #2 rst_n = 1'b0;
        #1;
        check("t6_bvalid_async", bvalid, 1'b0);
        check("t6_awready_async", awready, 1'b0);
        check("t6_arready_async", arready, 1'b0);
        check("t6_reg0_reset", reg_out[0 +: 32], 32'h0);
        check("t6_reg2_reset", reg_out[2*32 +: 32], 32'h0);
        check("t6_reg5_reset", reg_out[5*32 +: 32], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        #1;
        check("t6_rel_awready_low", awready, 1'b0);
        @(negedge clk);
        check("t6_rel_awready", awready, 1'b1);
        check("t6_no_stale_bvalid", bvalid, 1'b0);
        axi_write(32'h08, 32'h0BADF00D, 4'hF, resp, p1, p2);
        check("t6_bresp", resp, 2'b00);
        check("t6_pulse", p1, 16'h0004);
        check("t6_reg2", reg_out[2*32 +: 32], 32'h0BADF00D);
        axi_read(32'h08, rd, rr);
        check("t6_rdata", rd, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
